dcoef_deser: RTL and testbench
==============================

# dcoef_deser

Bit-serial to parallel coefficient collector: the receive end of the multiplier's coefficient bit-stream. Each cycle it takes one bit per lane, LSB first, from the coefficient serializer and rebuilds full N-bit coefficient words, one per lane. It presents each completed word set through a valid/ready handshake. A double buffer lets the next frame shift in while the previous one waits to be consumed.

## Interface
- N, 4, bits per coefficient (frame length in beats); N >= 2
- LANES, 4, parallel coefficient lanes (one dcoef bit each)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 clears the block at the next clk edge)
- in_valid  in  1  dcoef carries a valid bit-slice this cycle
- sof  in  1  start of frame; meaningful only with in_valid; this beat is bit 0
- dcoef  in  LANES  bit-slice; dcoef[k] is the current bit of lane k
- out_valid  out  1  cdata holds a complete, unconsumed frame
- out_ready  in  1  consumer accepts cdata when out_valid && out_ready
- cdata  out  LANES*N  reassembled words; lane k at cdata[k*N +: N]
- overrun  out  1  sticky: a completed frame was dropped because the output buffer was full
- busy  out  1  a frame is partially collected (bit count != 0)

## Operation
- Per-lane shift register sr_k (N bits). On an accepted beat: sr_k <= {dcoef[k], sr_k[N-1:1]}. The first beat ends in bit 0 after N beats (LSB first).
- Bit counter cnt, width clog2(N), counts accepted beats 0..N-1 and wraps to 0 after N-1.
- sof with in_valid forces this beat to be bit 0. cnt becomes 1, and bits of the abandoned partial frame are discarded by the shift. busy stays 1.
- Completion beat: in_valid && (cnt==N-1, or N==1 equivalent not supported). The full word {dcoef[k], sr_k[N-1:1]} is the frame.
- Output buffer FSM, two states:
  - EMPTY (out_valid=0): on completion, load cdata and go to FULL.
  - FULL (out_valid=1): on out_ready without completion, go to EMPTY with cdata unchanged.
  - FULL, completion and out_ready in the same cycle: load the new frame and stay FULL (no bubble).
  - FULL, completion without out_ready: drop the new frame, keep cdata, set overrun=1, stay FULL.
- overrun clears only on reset.
- in_valid=0: no state change in the shifters or cnt. sof without in_valid is ignored.
- Reset values: out_valid=0, cdata=0, overrun=0, busy=0, cnt=0, sr_k=0, state EMPTY.

## Timing
- All outputs are registered and update on the clk edge.
- Latency: out_valid rises on the edge that samples the Nth accepted beat. There is no additional pipeline stage.
- Sustained throughput: one frame per N cycles with in_valid held high and out_ready high. There are no stalls toward the sender; there is no backpressure signal.
- cdata stays stable while out_valid=1 until the handshake edge.
- Reset asserted mid-frame or with out_valid=1 discards everything. The first beat after reset release is bit 0, whether or not sof is present.

## Structure
- Shared package `dcoef_pkg`:
  - default N and LANES
  - CNT_W = clog2(N)
  - state enum {EMPTY, FULL}
- Sub-module `dcoef_lane_sipo` (one N-bit shift register plus output word register, with load enable) is instantiated LANES times.
- The top level holds cnt, the FSM and overrun.

## Test plan
- N=4, sof on beat 0, dcoef = 4'b0110, 4'b0101, 4'b0110, 4'b0101, out_ready=1 -> out_valid=1 after the 4th edge; cdata lanes 0..3 = 4'hA, 4'h5, 4'hF, 4'h0; out_valid drops the next cycle.
- Loopback from the coefficient serializer with words 4'h3, 4'hC, 4'h9, 4'h6, continuous for 3 frames, out_ready=1 -> three identical frames on consecutive N-cycle boundaries, overrun=0.
- out_ready=0 after frame 1 (A,5,F,0); second frame (1,2,3,4) completes -> cdata stays A,5,F,0, overrun=1. Then out_ready=1 -> out_valid=0, overrun still 1.
- out_valid=1 and the completion beat of frame 2 with out_ready=1 in the same cycle -> cdata becomes frame 2, out_valid stays 1 without a gap.
- Two beats of a frame, then sof with a fresh 4-beat frame (5,A,0,F) -> cdata = 5,A,0,F; the partial bits have no effect.
- reset=0 for one cycle after beat 2, then 4 beats without sof -> busy and cnt clear on the reset edge; the frame after reset decodes correctly; all outputs read 0 during reset.

Source files
------------

// File: rtl/dcoef_pkg.sv
// Shared types and defaults for the serial coefficient collector.
// Frame length, lane count and output buffer state encoding.
package dcoef_pkg;

    localparam int N_DEF     = 4;
    localparam int LANES_DEF = 4;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = cnt_w(N_DEF);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/dcoef_lane_sipo.sv
// One lane: LSB-first shift register plus the word register
// that captures the completed coefficient on load.
module dcoef_lane_sipo #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift,
    input  logic         din,
    input  logic         load,
    output logic [N-1:0] word
);

    logic [N-1:0] sr;
    logic [N-1:0] sr_nxt;

    assign sr_nxt = {din, sr[N-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr   <= '0;
            word <= '0;
        end else begin
            if (shift) sr <= sr_nxt;
            // Capture includes the bit arriving this beat
            if (load) word <= sr_nxt;
        end
    end

endmodule

// File: rtl/dcoef_deser.sv
// Bit-serial to parallel coefficient collector with a single
// output buffer; new frames shift in while the last one waits.
module dcoef_deser
    import dcoef_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               sof,
    input  logic [LANES-1:0]   dcoef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] cdata,
    output logic               overrun,
    output logic               busy
);

    localparam int CW = cnt_w(N);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last;
    logic          complete;
    logic          load;
    logic          ovr_set;
    state_t        state;
    state_t        state_nxt;

    assign last     = (cnt == CW'(N - 1));
    // A sof beat is always bit 0, so it can never complete a frame
    assign complete = in_valid && !sof && last;

    always_comb begin
        cnt_nxt = cnt;
        if (in_valid) begin
            if (sof)       cnt_nxt = CW'(1);
            else if (last) cnt_nxt = '0;
            else           cnt_nxt = cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovr_set   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (complete && out_ready) begin
                    load = 1'b1;
                end else if (complete) begin
                    ovr_set = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= EMPTY;
            cnt     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (cnt_nxt != '0);
            if (ovr_set) overrun <= 1'b1;
        end
    end

    assign out_valid = (state == FULL);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dcoef_lane_sipo #(.N(N)) u_lane (
            .clk   (clk),
            .reset (reset),
            .shift (in_valid),
            .din   (dcoef[k]),
            .load  (load),
            .word  (cdata[k*N +: N])
        );
    end

endmodule

// File: tb/tb_dcoef_deser.sv
// Scoreboard bench for dcoef_deser: frames are queued as sent
// and a monitor checks cdata on every output handshake.
module tb_dcoef_deser;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        sof;
    logic [3:0]  dcoef;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cdata;
    logic        overrun;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    dcoef_deser #(.N(4), .LANES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .sof       (sof),
        .dcoef     (dcoef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cdata     (cdata),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest queued frame
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_frame: got %h expected none", cdata);
            end else begin
                chk("cdata", cdata, q.pop_front());
            end
            n_pop++;
        end
    end

    function automatic logic [3:0] sl(input logic [15:0] w, input int b);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) s[k] = w[k*4 + b];
        return s;
    endfunction

    task automatic beat(input logic v, input logic s, input logic [3:0] d);
        in_valid = v;
        sof      = s;
        dcoef    = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input logic s,
                        input logic push);
        if (push) q.push_back(w);
        for (int b = 0; b < 4; b++) beat(1'b1, s && (b == 0), sl(w, b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int p0;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        sof       = 1'b0;
        dcoef     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_cdata", cdata, 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        reset = 1'b1;

        // Directed slice vector: lanes A,5,F,0
        q.push_back(16'h0F5A);
        beat(1'b1, 1'b1, 4'b0110);
        beat(1'b1, 1'b0, 4'b0101);
        chk("mid_busy", 16'(busy), 16'h1);
        beat(1'b1, 1'b0, 4'b0110);
        beat(1'b1, 1'b0, 4'b0101);
        chk("lat_out_valid", 16'(out_valid), 16'h1);
        chk("end_busy", 16'(busy), 16'h0);
        beat(1'b0, 1'b0, 4'b0000);
        chk("drop_out_valid", 16'(out_valid), 16'h0);

        // Loopback words 3,C,9,6 for three back-to-back frames
        p0 = n_pop;
        send(16'h69C3, 1'b1, 1'b1);
        send(16'h69C3, 1'b0, 1'b1);
        send(16'h69C3, 1'b0, 1'b1);
        beat(1'b0, 1'b0, 4'b0000);
        chk("loop_frames", 16'(n_pop - p0), 16'd3);
        chk("loop_overrun", 16'(overrun), 16'h0);

        // Overrun: frame 2 dropped while frame 1 waits
        out_ready = 1'b0;
        send(16'h0F5A, 1'b1, 1'b1);
        send(16'h4321, 1'b1, 1'b0);
        chk("ovr_cdata", cdata, 16'h0F5A);
        chk("ovr_flag", 16'(overrun), 16'h1);
        out_ready = 1'b1;
        beat(1'b0, 1'b0, 4'b0000);
        chk("ovr_out_valid", 16'(out_valid), 16'h0);
        chk("ovr_sticky", 16'(overrun), 16'h1);

        // Handshake and completion on the same edge: no bubble
        out_ready = 1'b0;
        send(16'h0F5A, 1'b1, 1'b1);
        q.push_back(16'h4321);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) out_ready = 1'b1;
            beat(1'b1, b == 0, sl(16'h4321, b));
        end
        chk("b2b_out_valid", 16'(out_valid), 16'h1);
        chk("b2b_cdata", cdata, 16'h4321);
        beat(1'b0, 1'b0, 4'b0000);

        // Abandoned partial frame, then a fresh sof frame 5,A,0,F
        beat(1'b1, 1'b1, 4'b1111);
        beat(1'b1, 1'b0, 4'b1010);
        send(16'hF0A5, 1'b1, 1'b1);
        beat(1'b0, 1'b0, 4'b0000);

        // Reset mid-frame, then a frame with no sof
        beat(1'b1, 1'b1, 4'b1111);
        beat(1'b1, 1'b0, 4'b1111);
        reset = 1'b0;
        beat(1'b0, 1'b0, 4'b0000);
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_out_valid", 16'(out_valid), 16'h0);
        chk("mrst_cdata", cdata, 16'h0);
        chk("mrst_overrun", 16'(overrun), 16'h0);
        reset = 1'b1;
        send(16'h69C3, 1'b0, 1'b1);
        beat(1'b0, 1'b0, 4'b0000);

        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
